// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the miniALU entry sequencer.
// The state order also fixes the one-hot LED encoding.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ENTER_OP,
    EXEC,
    SHOW
  } state_e;

  localparam int OPERAND_W = 4;
  localparam int VALUE_W   = 20;
  localparam int SW_OP_BIT = 8;
  localparam int SW_EN_BIT = 9;

  function automatic logic [4:0] state_onehot(state_e s);
    logic [4:0] one;
    one = 5'b00001;
    return one << s;
  endfunction

  function automatic logic is_entry(state_e s);
    return (s == ENTER_A) || (s == ENTER_B) || (s == ENTER_OP);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Turns a raw, bouncy, active-low pushbutton into a single-cycle press pulse.
// The key is synchronized, then accepted only after DEBOUNCE_CYCLES stable samples.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Only the accepted falling edge is a press; release is silent.
    press_d = stable_q & ~stable_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_entry_sequencer.sv
// Steps the user through A, B and op entry for the miniALU with one button,
// captures the result and drives the blinking/steady seven-segment inputs.
module alu_entry_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  input  logic [9:0]  switches,
  input  logic [19:0] alu_result,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic        alu_op,
  output logic [19:0] disp_value,
  output logic        disp_blank,
  output logic [9:0]  leds
);

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic press;

  state_e                 state_q, state_d;
  logic [OPERAND_W-1:0]   alu_a_q, alu_a_d;
  logic [OPERAND_W-1:0]   alu_b_q, alu_b_d;
  logic                   alu_op_q, alu_op_d;
  logic [VALUE_W-1:0]     result_q, result_d;
  logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
  logic                   phase_q, phase_d;
  logic [VALUE_W-1:0]     disp_value_q, disp_value_d;
  logic                   disp_blank_q, disp_blank_d;
  logic [9:0]             leds_q, leds_d;

  // Switches [7:4] have no function on this board.
  logic unused_switches;
  assign unused_switches = ^switches[7:4];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_n),
    .press(press)
  );

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;

    unique case (state_q)
      ENTER_A: if (press) begin
        alu_a_d = switches[OPERAND_W-1:0];
        state_d = ENTER_B;
      end
      ENTER_B: if (press) begin
        alu_b_d = switches[OPERAND_W-1:0];
        state_d = ENTER_OP;
      end
      ENTER_OP: if (press) begin
        alu_op_d = switches[SW_OP_BIT];
        state_d  = EXEC;
      end
      // Operands have been stable for a full cycle here, so the ALU output is settled.
      EXEC: begin
        result_d = alu_result;
        state_d  = SHOW;
      end
      SHOW: if (press) begin
        state_d = ENTER_A;
      end
      default: state_d = ENTER_A;
    endcase

    // Blink phase restarts visible whenever the state changes.
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    // Outputs are built from next-state values so they line up with the state register.
    unique case (state_d)
      ENTER_A, ENTER_B: disp_value_d = VALUE_W'(switches[OPERAND_W-1:0]);
      ENTER_OP:         disp_value_d = VALUE_W'(switches[SW_OP_BIT]);
      default:          disp_value_d = result_d;
    endcase

    disp_blank_d = ~switches[SW_EN_BIT] | (phase_d & is_entry(state_d));

    leds_d      = '0;
    leds_d[4:0] = state_onehot(state_d);
    leds_d[9]   = alu_op_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ENTER_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= 1'b0;
      result_q     <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      disp_value_q <= '0;
      disp_blank_q <= 1'b1;
      leds_q       <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      result_q     <= result_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      disp_value_q <= disp_value_d;
      disp_blank_q <= disp_blank_d;
      leds_q       <= leds_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign disp_value = disp_value_q;
  assign disp_blank = disp_blank_q;
  assign leds       = leds_q;

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Self-checking bench: directed scenarios plus random key/switch activity,
// compared every cycle against a behavioural model of the entry sequence.
module tb_alu_entry_sequencer;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int S_A = 0, S_B = 1, S_OP = 2, S_EX = 3, S_SH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_n;
  logic [9:0]  switches;
  logic [19:0] alu_result;
  logic [3:0]  alu_a, alu_b;
  logic        alu_op;
  logic [19:0] disp_value;
  logic        disp_blank;
  logic [9:0]  leds;

  int vectors     = 0;
  int miscompares = 0;

  alu_entry_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLINK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .switches  (switches),
    .alu_result(alu_result),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .disp_value(disp_value),
    .disp_blank(disp_blank),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  // miniALU stand-in: op 0 adds, op 1 multiplies.
  assign alu_result = alu_op ? ({16'b0, alu_a} * {16'b0, alu_b})
                             : ({16'b0, alu_a} + {16'b0, alu_b});

  // Reference model state.
  int          m_state;
  int          m_t;
  logic [3:0]  m_a, m_b;
  logic        m_op;
  logic [19:0] m_res;
  logic        m_lvl, m_pend;
  logic        hist[$];
  logic [9:0]  e_leds;
  logic [19:0] e_val;
  logic        e_blank;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_A; m_t = 0;
    m_a = '0; m_b = '0; m_op = 1'b0; m_res = '0;
    m_lvl = 1'b1; m_pend = 1'b0;
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b1);
    e_leds = '0; e_val = '0; e_blank = 1'b1;
  endtask

  // Applies one clock edge worth of behaviour, using the inputs present at the edge.
  task automatic model_step();
    int   nxt;
    logic all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    nxt = m_state;
    case (m_state)
      S_A:  if (m_pend) begin m_a  = switches[3:0]; nxt = S_B;  end
      S_B:  if (m_pend) begin m_b  = switches[3:0]; nxt = S_OP; end
      S_OP: if (m_pend) begin m_op = switches[8];   nxt = S_EX; end
      S_EX: begin
        m_res = m_op ? 20'(int'(m_a) * int'(m_b)) : 20'(int'(m_a) + int'(m_b));
        nxt   = S_SH;
      end
      default: if (m_pend) nxt = S_A;
    endcase
    m_t     = (nxt == m_state) ? m_t + 1 : 0;
    m_state = nxt;
    e_leds    = (10'd1 << m_state);
    e_leds[9] = m_op;
    if (m_state <= S_B)       e_val = {16'b0, switches[3:0]};
    else if (m_state == S_OP) e_val = {19'b0, switches[8]};
    else                      e_val = m_res;
    e_blank = !switches[9] || ((((m_t / BLINK) % 2) == 1) && (m_state <= S_OP));
    // The key level is accepted after DEB consecutive differing samples, two cycles late.
    hist.push_back(key_n);
    void'(hist.pop_front());
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) if (hist[i] == m_lvl) all_diff = 1'b0;
    m_pend = 1'b0;
    if (all_diff) begin
      m_lvl  = ~m_lvl;
      m_pend = (m_lvl == 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("leds",       20'(leds),       20'(e_leds));
    check("disp_value", disp_value,      e_val);
    check("disp_blank", 20'(disp_blank), 20'(e_blank));
    check("alu_a",      20'(alu_a),      20'(m_a));
    check("alu_b",      20'(alu_b),      20'(m_b));
    check("alu_op",     20'(alu_op),     20'(m_op));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int low, input int high);
    key_n = 1'b0;
    repeat (low) tick();
    key_n = 1'b1;
    repeat (high) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; key_n = 1'b1; switches = '0;
    model_reset();

    // Reset state.
    do_reset();
    check("reset_leds", 20'(leds), 20'h0);
    check("reset_blank", 20'(disp_blank), 20'h1);

    // Full 9 * 5 multiply sequence.
    switches = 10'h209; press(6, 8);
    switches = 10'h205; press(6, 8);
    switches = 10'h300; press(6, 8);
    check("t1_value", disp_value, 20'd45);
    check("t1_leds", 20'(leds), 20'(10'b10_0001_0000));
    check("t1_blank", 20'(disp_blank), 20'h0);

    // Short glitch is not a press.
    do_reset();
    switches = 10'h200;
    key_n = 1'b0; idle(2); key_n = 1'b1;
    idle(10);
    check("t2_leds", 20'(leds), 20'(10'b00_0000_0001));

    // Blinking in ENTER_A, then forced blank.
    do_reset();
    switches = 10'h200; idle(40);
    switches = 10'h000; idle(20);
    check("t3_blank_forced", 20'(disp_blank), 20'h1);

    // Reset while in ENTER_OP.
    do_reset();
    switches = 10'h203; press(6, 8);
    switches = 10'h207; press(6, 8);
    check("t4_in_op", 20'(leds[4:0]), 20'(5'b00100));
    rst = 1'b1; tick(); rst = 1'b0;
    check("t4_leds", 20'(leds), 20'h0);
    check("t4_value", disp_value, 20'h0);
    check("t4_blank", 20'(disp_blank), 20'h1);
    tick();
    check("t4_alu_a", 20'(alu_a), 20'h0);

    // Long hold yields one transition.
    do_reset();
    switches = 10'h20A;
    key_n = 1'b0; idle(100); key_n = 1'b1; idle(10);
    check("t5_state", 20'(leds[4:0]), 20'(5'b00010));
    check("t5_alu_a", 20'(alu_a), 20'hA);

    // Finish 10 * 3, then return to ENTER_A from SHOW.
    switches = 10'h203; press(6, 8);
    switches = 10'h301; press(6, 8);
    check("t6_result", disp_value, 20'd30);
    switches = 10'h20C; press(6, 8);
    check("t6_state", 20'(leds[4:0]), 20'(5'b00001));
    check("t6_value", disp_value, 20'hC);
    check("t6_kept_a", 20'(alu_a), 20'hA);
    check("t6_kept_b", 20'(alu_b), 20'h3);
    check("t6_kept_op", 20'(alu_op), 20'h1);

    // Random key and switch activity.
    repeat (250) begin
      r = $urandom_range(0, 19);
      switches = 10'($urandom);
      if (r < 12) begin
        press($urandom_range(4, 10), $urandom_range(6, 12));
      end else if (r < 15) begin
        key_n = 1'b0; idle($urandom_range(1, 3)); key_n = 1'b1;
        idle($urandom_range(1, 6));
      end else if (r < 17) begin
        repeat ($urandom_range(2, 6)) begin
          key_n = 1'($urandom);
          tick();
        end
        key_n = 1'b1;
        idle($urandom_range(1, 8));
      end else if (r < 19) begin
        idle($urandom_range(1, 20));
      end else begin
        key_n = 1'($urandom);
        do_reset();
        key_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
